// File: rtl/bp_fe_fetch_buffer.sv
// bp_fe_fetch_buffer
//   In-order landing buffer between bp_fe_icache and the decode/issue queue.
//   One slot is allocated per fetch issued to the I$; the returned
//   instruction (or miss) is captured into that slot. The head slot is shown
//   to the consumer with its PC. Issue credit is granted only while a free
//   slot exists. Redirect flushes are handled while fetches are in flight.
//
//   Optional feature: define BP_FE_FETCH_BUFFER_PERF_EN to add the
//   saturating drop_cnt_o / miss_cnt_o performance counters.
//
// Handshakes:
//   fetch_v_i/credit_o : credit_o is a function of registered state only.
//                        fetch_v_i may be high only while credit_o is high;
//                        a fetch offered without credit is dropped.
//   v_o/yumi_i         : v_o never depends on yumi_i. yumi_i may be high only
//                        while v_o is high and means the head is consumed at
//                        this clock edge. yumi_i is ignored during flush_i.
//
// Slot lifecycle: EMPTY -> PEND (issue) -> READY (hit) | DEAD (miss/doomed)
//                 READY -> EMPTY (yumi), DEAD -> EMPTY (auto-free at head).
// Pointer regions: [rptr, fptr) resolved (READY/DEAD), [fptr, wptr) PEND.
module bp_fe_fetch_buffer #(
    parameter int vaddr_width_p = 39,
    parameter int instr_width_p = 32,
    parameter int els_p         = 8
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic                     flush_i,
    input  logic                     fetch_v_i,
    input  logic [vaddr_width_p-1:0] fetch_vaddr_i,
    output logic                     credit_o,
    input  logic [instr_width_p-1:0] icache_data_i,
    input  logic                     icache_data_v_i,
    input  logic                     icache_miss_i,
    output logic [instr_width_p-1:0] instr_o,
    output logic [vaddr_width_p-1:0] pc_o,
    output logic                     v_o,
`ifdef BP_FE_FETCH_BUFFER_PERF_EN
    output logic [31:0]              drop_cnt_o,
    output logic [31:0]              miss_cnt_o,
`endif
    input  logic                     yumi_i
);

    localparam int idx_w = $clog2(els_p);
    localparam int ptr_w = idx_w + 1;

    typedef enum logic [1:0] {
        SLOT_EMPTY = 2'd0,
        SLOT_PEND  = 2'd1,
        SLOT_READY = 2'd2,
        SLOT_DEAD  = 2'd3
    } slot_state_e;

    // Slot storage
    slot_state_e              state_r [els_p];
    logic [els_p-1:0]         doom_r;
    logic [vaddr_width_p-1:0] vaddr_r [els_p];
    logic [instr_width_p-1:0] instr_r [els_p];

    // Pointers carry a wrap bit so full and empty are distinguishable
    logic [ptr_w-1:0] wptr_r, fptr_r, rptr_r;
    logic [ptr_w-1:0] wptr_n, fptr_n, rptr_n;
    logic [ptr_w-1:0] count;
    logic [idx_w-1:0] widx, fidx, ridx;

    slot_state_e head_state;
    logic        issue_v;
    logic        resolve_v;
    logic        resolve_ready;
    logic        auto_free;
    logic        pop;

    // Decode occupancy, credit, resolve outcome and head status from registered state
    always_comb begin
        widx          = wptr_r[idx_w-1:0];
        fidx          = fptr_r[idx_w-1:0];
        ridx          = rptr_r[idx_w-1:0];
        count         = wptr_r - rptr_r;
        credit_o      = (count != ptr_w'(els_p));
        issue_v       = fetch_v_i & credit_o;
        // A resolve with nothing outstanding is an upstream error and is ignored
        resolve_v     = (icache_data_v_i | icache_miss_i) & (fptr_r != wptr_r);
        // data_v together with miss is illegal; it is treated as a miss
        resolve_ready = resolve_v & icache_data_v_i & ~icache_miss_i & ~doom_r[fidx];
        head_state    = state_r[ridx];
        v_o           = (head_state == SLOT_READY);
        auto_free     = (head_state == SLOT_DEAD);
        // A flush moves rptr wholesale, so no single-slot pop happens then
        pop           = ~flush_i & ((v_o & yumi_i) | auto_free);
    end

    // Next pointer values; a flush frees everything already resolved, including this cycle's resolve
    always_comb begin
        wptr_n = wptr_r + ptr_w'(issue_v);
        fptr_n = fptr_r + ptr_w'(resolve_v);
        rptr_n = flush_i ? fptr_n : (rptr_r + ptr_w'(pop));
    end

    // Head outputs are zero whenever the head is not valid
    always_comb begin
        instr_o = v_o ? instr_r[ridx] : '0;
        pc_o    = v_o ? vaddr_r[ridx] : '0;
    end

    // Pointer registers
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wptr_r <= '0;
            fptr_r <= '0;
            rptr_r <= '0;
        end else begin
            wptr_r <= wptr_n;
            fptr_r <= fptr_n;
            rptr_r <= rptr_n;
        end
    end

    // Per-slot state and doom bit updates
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            for (int i = 0; i < els_p; i++) begin
                state_r[i] <= SLOT_EMPTY;
                doom_r[i]  <= 1'b0;
            end
        end else begin
            for (int i = 0; i < els_p; i++) begin
                if (flush_i) begin
                    if ((state_r[i] == SLOT_READY) || (state_r[i] == SLOT_DEAD)) begin
                        state_r[i] <= SLOT_EMPTY;
                    end else if (state_r[i] == SLOT_PEND) begin
                        if (resolve_v && (fidx == idx_w'(i))) begin
                            // Resolved in the flush cycle: discarded and freed
                            state_r[i] <= SLOT_EMPTY;
                        end else begin
                            // Still in flight: its result must never reach the consumer
                            doom_r[i] <= 1'b1;
                        end
                    end
                end else begin
                    if (resolve_v && (fidx == idx_w'(i))) begin
                        state_r[i] <= resolve_ready ? SLOT_READY : SLOT_DEAD;
                    end
                    if (pop && (ridx == idx_w'(i))) begin
                        state_r[i] <= SLOT_EMPTY;
                    end
                end
                // A fetch in the flush cycle belongs to the new stream
                if (issue_v && (widx == idx_w'(i))) begin
                    state_r[i] <= SLOT_PEND;
                    doom_r[i]  <= 1'b0;
                end
            end
        end
    end

    // Slot payload capture; contents are don't-care until the slot state says otherwise
    always_ff @(posedge clk_i) begin
        if (issue_v) begin
            vaddr_r[widx] <= fetch_vaddr_i;
        end
        if (resolve_ready && !flush_i) begin
            instr_r[fidx] <= icache_data_i;
        end
    end

`ifdef BP_FE_FETCH_BUFFER_PERF_EN
    logic [31:0] drop_inc;
    logic [32:0] drop_sum;
    logic [32:0] miss_sum;

    // Slots discarded this cycle: READY slots plus any resolve swept by a flush, or a doomed resolve
    always_comb begin
        drop_inc = '0;
        if (flush_i) begin
            for (int i = 0; i < els_p; i++) begin
                if (state_r[i] == SLOT_READY) begin
                    drop_inc = drop_inc + 32'd1;
                end
            end
            if (resolve_v) begin
                drop_inc = drop_inc + 32'd1;
            end
        end else if (resolve_v && doom_r[fidx]) begin
            drop_inc = drop_inc + 32'd1;
        end
        drop_sum = {1'b0, drop_cnt_o} + {1'b0, drop_inc};
        miss_sum = {1'b0, miss_cnt_o} + 33'(resolve_v & icache_miss_i);
    end

    // Saturating performance counters
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            drop_cnt_o <= '0;
            miss_cnt_o <= '0;
        end else begin
            drop_cnt_o <= drop_sum[32] ? 32'hFFFF_FFFF : drop_sum[31:0];
            miss_cnt_o <= miss_sum[32] ? 32'hFFFF_FFFF : miss_sum[31:0];
        end
    end
`endif

endmodule

// File: tb/tb_bp_fe_fetch_buffer.sv
// Self-checking bench for bp_fe_fetch_buffer. The reference model keeps the
// outstanding fetches as a queue of records (oldest first) and applies the
// buffer rules per cycle; directed scenarios also check fixed expectations.
module tb_bp_fe_fetch_buffer;

    localparam int VW  = 39;
    localparam int IW  = 32;
    localparam int ELS = 8;

    localparam int ST_PEND  = 0;
    localparam int ST_READY = 1;
    localparam int ST_DEAD  = 2;

    logic          clk_i;
    logic          reset_i;
    logic          flush_i;
    logic          fetch_v_i;
    logic [VW-1:0] fetch_vaddr_i;
    logic          credit_o;
    logic [IW-1:0] icache_data_i;
    logic          icache_data_v_i;
    logic          icache_miss_i;
    logic [IW-1:0] instr_o;
    logic [VW-1:0] pc_o;
    logic          v_o;
    logic          yumi_i;
`ifdef BP_FE_FETCH_BUFFER_PERF_EN
    logic [31:0]   drop_cnt_o;
    logic [31:0]   miss_cnt_o;
`endif

    int errors = 0;
    int checks = 0;

    // ---------------- clock ----------------
    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    bp_fe_fetch_buffer #(
        .vaddr_width_p(VW),
        .instr_width_p(IW),
        .els_p        (ELS)
    ) dut (
        .clk_i          (clk_i),
        .reset_i        (reset_i),
        .flush_i        (flush_i),
        .fetch_v_i      (fetch_v_i),
        .fetch_vaddr_i  (fetch_vaddr_i),
        .credit_o       (credit_o),
        .icache_data_i  (icache_data_i),
        .icache_data_v_i(icache_data_v_i),
        .icache_miss_i  (icache_miss_i),
        .instr_o        (instr_o),
        .pc_o           (pc_o),
        .v_o            (v_o),
`ifdef BP_FE_FETCH_BUFFER_PERF_EN
        .drop_cnt_o     (drop_cnt_o),
        .miss_cnt_o     (miss_cnt_o),
`endif
        .yumi_i         (yumi_i)
    );

    // ---------------- reference model ----------------
    typedef struct {
        logic [VW-1:0] pc;
        logic [IW-1:0] instr;
        int            st;
        bit            doom;
    } ent_t;

    ent_t mq[$];
    int   exp_drop = 0;
    int   exp_miss = 0;

    function automatic void model_step(input logic rst, input logic fl, input logic fv,
                                       input logic [VW-1:0] va, input logic dv,
                                       input logic [IW-1:0] d, input logic ms, input logic y);
        int   pi;
        int   nfree;
        bit   res;
        bit   pop;
        bit   cr;
        ent_t e;
        if (rst) begin
            mq.delete();
            exp_drop = 0;
            exp_miss = 0;
            return;
        end
        cr = (mq.size() < ELS);
        pi = -1;
        for (int i = 0; i < mq.size(); i++) begin
            if (mq[i].st == ST_PEND) begin
                pi = i;
                break;
            end
        end
        res = (dv || ms) && (pi >= 0);
        pop = 1'b0;
        if (mq.size() > 0) pop = ((mq[0].st == ST_READY) && y) || (mq[0].st == ST_DEAD);
        if (res && ms) exp_miss++;
        if (fl) begin
            nfree = (pi >= 0) ? pi : mq.size();
            for (int i = 0; i < nfree; i++) begin
                if (mq[i].st == ST_READY) exp_drop++;
            end
            if (res) begin
                nfree++;
                exp_drop++;
            end
            repeat (nfree) void'(mq.pop_front());
            for (int i = 0; i < mq.size(); i++) begin
                e = mq[i];
                e.doom = 1'b1;
                mq[i] = e;
            end
        end else begin
            if (res) begin
                e = mq[pi];
                if (dv && !ms && !e.doom) begin
                    e.st = ST_READY;
                    e.instr = d;
                end else begin
                    e.st = ST_DEAD;
                    if (e.doom) exp_drop++;
                end
                mq[pi] = e;
            end
            if (pop) void'(mq.pop_front());
        end
        if (fv && cr) begin
            e.pc = va;
            e.instr = '0;
            e.st = ST_PEND;
            e.doom = 1'b0;
            mq.push_back(e);
        end
    endfunction

    function automatic logic m_v();
        return (mq.size() > 0) && (mq[0].st == ST_READY);
    endfunction

    function automatic logic m_credit();
        return (mq.size() < ELS);
    endfunction

    function automatic logic [VW-1:0] m_pc();
        return (mq.size() > 0) ? mq[0].pc : '0;
    endfunction

    function automatic logic [IW-1:0] m_instr();
        return (mq.size() > 0) ? mq[0].instr : '0;
    endfunction

    // ---------------- driver ----------------
    // Applies one cycle of inputs, advances the model at the edge, returns 1 time unit later.
    task automatic tick(input logic rst, input logic fl, input logic fv, input logic [VW-1:0] va,
                        input logic dv, input logic [IW-1:0] d, input logic ms, input logic y);
        reset_i         = rst;
        flush_i         = fl;
        fetch_v_i       = fv;
        fetch_vaddr_i   = va;
        icache_data_v_i = dv;
        icache_data_i   = d;
        icache_miss_i   = ms;
        yumi_i          = y;
        @(posedge clk_i);
        model_step(rst, fl, fv, va, dv, d, ms, y);
        #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        tick(1'b1, 1'b0, 1'b0, '0, 1'b0, '0, 1'b0, 1'b0);
        tick(1'b1, 1'b0, 1'b0, '0, 1'b0, '0, 1'b0, 1'b0);
        checks++;
        if (v_o !== 1'b0) begin errors++; $display("FAIL reset_v got=%0b exp=0", v_o); end
        checks++;
        if (credit_o !== 1'b1) begin errors++; $display("FAIL reset_credit got=%0b exp=1", credit_o); end
        checks++;
        if (instr_o !== '0) begin errors++; $display("FAIL reset_instr got=%h exp=0", instr_o); end
        checks++;
        if (pc_o !== '0) begin errors++; $display("FAIL reset_pc got=%h exp=0", pc_o); end
    endtask

    task automatic test_streaming();
        logic [VW-1:0]    pcs [4];
        logic [IW-1:0]    ds  [4];
        logic [VW+IW-1:0] exp_q[$];
        logic [VW+IW-1:0] got_q[$];
        int               first_v;
        pcs = '{VW'(32'h8000_0000), VW'(32'h8000_0004), VW'(32'h8000_0008), VW'(32'h8000_000C)};
        ds  = '{32'h13, 32'h93, 32'h113, 32'h193};
        for (int i = 0; i < 4; i++) exp_q.push_back({pcs[i], ds[i]});
        first_v = -1;
        tick(1'b1, 1'b0, 1'b0, '0, 1'b0, '0, 1'b0, 1'b0);
        for (int c = 0; c < 8; c++) begin
            if (v_o) got_q.push_back({pc_o, instr_o});
            tick(1'b0, 1'b0, (c < 4), pcs[c % 4], (c >= 1) && (c <= 4), ds[(c + 3) % 4], 1'b0, 1'b1);
            checks++;
            if (v_o !== m_v() || credit_o !== m_credit()) begin
                errors++;
                $display("FAIL stream_hs cyc=%0d got v=%0b credit=%0b exp v=%0b credit=%0b", c + 1, v_o, credit_o, m_v(), m_credit());
            end
            if (m_v()) begin
                checks++;
                if (pc_o !== m_pc() || instr_o !== m_instr()) begin
                    errors++;
                    $display("FAIL stream_head cyc=%0d got pc=%h instr=%h exp pc=%h instr=%h", c + 1, pc_o, instr_o, m_pc(), m_instr());
                end
            end
            if (v_o && first_v < 0) first_v = c + 1;
        end
        checks++;
        if (first_v !== 2) begin errors++; $display("FAIL stream_latency got=%0d exp=2", first_v); end
        checks++;
        if (got_q.size() !== exp_q.size()) begin
            errors++; $display("FAIL stream_count got=%0d exp=%0d", got_q.size(), exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                checks++;
                if (got_q[i] !== exp_q[i]) begin
                    errors++; $display("FAIL stream_order idx=%0d got=%h exp=%h", i, got_q[i], exp_q[i]);
                end
            end
        end
    endtask

    task automatic test_full_credit();
        logic [VW+IW-1:0] exp_q[$];
        logic [VW+IW-1:0] got_q[$];
        for (int i = 0; i < 8; i++) exp_q.push_back({VW'(32'h1000 + 4 * i), IW'(32'hA000 + i)});
        tick(1'b1, 1'b0, 1'b0, '0, 1'b0, '0, 1'b0, 1'b0);
        // The ninth fetch (c==8) is offered without credit and must be dropped
        for (int c = 0; c < 9; c++) begin
            tick(1'b0, 1'b0, 1'b1, VW'(32'h1000 + 4 * c), (c >= 1), IW'(32'hA000 + c - 1), 1'b0, 1'b0);
            checks++;
            if (v_o !== m_v() || credit_o !== m_credit()) begin
                errors++;
                $display("FAIL full_hs cyc=%0d got v=%0b credit=%0b exp v=%0b credit=%0b", c + 1, v_o, credit_o, m_v(), m_credit());
            end
            if (c == 7) begin
                checks++;
                if (credit_o !== 1'b0) begin errors++; $display("FAIL full_credit_low got=%0b exp=0", credit_o); end
            end
        end
        if (v_o) got_q.push_back({pc_o, instr_o});
        tick(1'b0, 1'b0, 1'b0, '0, 1'b0, '0, 1'b0, 1'b1);
        checks++;
        if (credit_o !== 1'b1) begin errors++; $display("FAIL full_credit_back got=%0b exp=1", credit_o); end
        for (int c = 0; c < 10; c++) begin
            if (v_o) got_q.push_back({pc_o, instr_o});
            tick(1'b0, 1'b0, 1'b0, '0, 1'b0, '0, 1'b0, 1'b1);
            checks++;
            if (v_o !== m_v() || credit_o !== m_credit()) begin
                errors++;
                $display("FAIL full_drain_hs step=%0d got v=%0b credit=%0b exp v=%0b credit=%0b", c, v_o, credit_o, m_v(), m_credit());
            end
        end
        checks++;
        if (got_q.size() !== exp_q.size()) begin
            errors++; $display("FAIL full_count got=%0d exp=%0d", got_q.size(), exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                checks++;
                if (got_q[i] !== exp_q[i]) begin
                    errors++; $display("FAIL full_order idx=%0d got=%h exp=%h", i, got_q[i], exp_q[i]);
                end
            end
        end
    endtask

    task automatic test_miss_skip();
        logic [VW+IW-1:0] exp_q[$];
        logic [VW+IW-1:0] got_q[$];
        exp_q.push_back({VW'(32'h4000), IW'(32'hAAAA)});
        exp_q.push_back({VW'(32'h4008), IW'(32'hCCCC)});
        tick(1'b1, 1'b0, 1'b0, '0, 1'b0, '0, 1'b0, 1'b0);
        for (int c = 0; c < 6; c++) begin
            if (v_o) got_q.push_back({pc_o, instr_o});
            tick(1'b0, 1'b0, (c < 3), VW'(32'h4000 + 4 * c),
                 (c == 1) || (c == 3), (c == 1) ? IW'(32'hAAAA) : IW'(32'hCCCC), (c == 2), 1'b1);
            checks++;
            if (v_o !== m_v() || credit_o !== m_credit()) begin
                errors++;
                $display("FAIL miss_hs cyc=%0d got v=%0b credit=%0b exp v=%0b credit=%0b", c + 1, v_o, credit_o, m_v(), m_credit());
            end
            if (c == 2) begin
                checks++;
                if (v_o !== 1'b0) begin errors++; $display("FAIL miss_gap got=%0b exp=0", v_o); end
            end
        end
        checks++;
        if (got_q.size() !== 2) begin
            errors++; $display("FAIL miss_count got=%0d exp=2", got_q.size());
        end else begin
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (got_q[i] !== exp_q[i]) begin
                    errors++; $display("FAIL miss_order idx=%0d got=%h exp=%h", i, got_q[i], exp_q[i]);
                end
            end
        end
    endtask

    task automatic test_flush_in_flight();
        logic [VW+IW-1:0] exp_q[$];
        logic [VW+IW-1:0] got_q[$];
        logic             fl;
        logic             y;
        exp_q.push_back({VW'(32'h9000_0000), IW'(32'h5008)});
        tick(1'b1, 1'b0, 1'b0, '0, 1'b0, '0, 1'b0, 1'b0);
        for (int c = 0; c < 11; c++) begin
            fl = (c == 4);
            y  = (c >= 5);
            if (v_o && y && !fl) got_q.push_back({pc_o, instr_o});
            tick(1'b0, fl, (c < 4) || (c == 7), (c < 4) ? VW'(32'h100 + 4 * c) : VW'(32'h9000_0000),
                 (c == 1) || (c == 2) || (c == 5) || (c == 6) || (c == 8), IW'(32'h5000 + c), 1'b0, y);
            checks++;
            if (v_o !== m_v() || credit_o !== m_credit()) begin
                errors++;
                $display("FAIL flush_hs cyc=%0d got v=%0b credit=%0b exp v=%0b credit=%0b", c + 1, v_o, credit_o, m_v(), m_credit());
            end
            if (c == 4) begin
                checks++;
                if (v_o !== 1'b0) begin errors++; $display("FAIL flush_next_v got=%0b exp=0", v_o); end
            end
        end
        checks++;
        if (got_q.size() !== 1) begin
            errors++; $display("FAIL flush_count got=%0d exp=1", got_q.size());
        end else begin
            checks++;
            if (got_q[0] !== exp_q[0]) begin errors++; $display("FAIL flush_new got=%h exp=%h", got_q[0], exp_q[0]); end
        end
`ifdef BP_FE_FETCH_BUFFER_PERF_EN
        checks++;
        if (drop_cnt_o !== 32'd4) begin errors++; $display("FAIL flush_drop_cnt got=%0d exp=4", drop_cnt_o); end
`endif
        // All slots must be free again: exactly eight fetches fit
        for (int k = 0; k < 8; k++) begin
            tick(1'b0, 1'b0, 1'b1, VW'(32'hA00 + 4 * k), 1'b0, '0, 1'b0, 1'b0);
            checks++;
            if (credit_o !== ((k < 7) ? 1'b1 : 1'b0)) begin
                errors++; $display("FAIL flush_refill_credit k=%0d got=%0b exp=%0b", k, credit_o, (k < 7));
            end
        end
    endtask

    task automatic test_flush_corner();
        logic [VW+IW-1:0] exp_q[$];
        logic [VW+IW-1:0] got_q[$];
        exp_q.push_back({VW'(32'h300), IW'(32'h33)});
        tick(1'b1, 1'b0, 1'b0, '0, 1'b0, '0, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 1'b1, VW'(32'h200), 1'b0, '0, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 1'b1, VW'(32'h204), 1'b1, IW'(32'h11), 1'b0, 1'b0);
        checks++;
        if (v_o !== 1'b1 || pc_o !== VW'(32'h200)) begin
            errors++; $display("FAIL corner_pre got v=%0b pc=%h exp v=1 pc=200", v_o, pc_o);
        end
        // flush + resolve of B + yumi of A + new issue N, all in one cycle
        tick(1'b0, 1'b1, 1'b1, VW'(32'h300), 1'b1, IW'(32'h22), 1'b0, 1'b1);
        checks++;
        if (v_o !== 1'b0) begin errors++; $display("FAIL corner_next_v got=%0b exp=0", v_o); end
        tick(1'b0, 1'b0, 1'b0, '0, 1'b1, IW'(32'h33), 1'b0, 1'b0);
        for (int c = 0; c < 3; c++) begin
            if (v_o) got_q.push_back({pc_o, instr_o});
            tick(1'b0, 1'b0, 1'b0, '0, 1'b0, '0, 1'b0, 1'b1);
            checks++;
            if (v_o !== m_v() || credit_o !== m_credit()) begin
                errors++;
                $display("FAIL corner_hs step=%0d got v=%0b credit=%0b exp v=%0b credit=%0b", c, v_o, credit_o, m_v(), m_credit());
            end
        end
        checks++;
        if (got_q.size() !== 1) begin
            errors++; $display("FAIL corner_count got=%0d exp=1", got_q.size());
        end else begin
            checks++;
            if (got_q[0] !== exp_q[0]) begin errors++; $display("FAIL corner_new got=%h exp=%h", got_q[0], exp_q[0]); end
        end
`ifdef BP_FE_FETCH_BUFFER_PERF_EN
        checks++;
        if (drop_cnt_o !== 32'd2) begin errors++; $display("FAIL corner_drop_cnt got=%0d exp=2", drop_cnt_o); end
`endif
    endtask

    task automatic test_reset_mid();
        tick(1'b1, 1'b0, 1'b0, '0, 1'b0, '0, 1'b0, 1'b0);
        for (int c = 0; c < 5; c++) begin
            tick(1'b0, 1'b0, 1'b1, VW'(32'h600 + 4 * c), (c >= 1) && (c <= 3), IW'(32'h6000 + c), 1'b0, 1'b0);
        end
        checks++;
        if (v_o !== m_v() || credit_o !== m_credit()) begin
            errors++; $display("FAIL rmid_pre got v=%0b credit=%0b exp v=%0b credit=%0b", v_o, credit_o, m_v(), m_credit());
        end
        tick(1'b1, 1'b0, 1'b0, '0, 1'b0, '0, 1'b0, 1'b0);
        checks++;
        if (v_o !== 1'b0 || credit_o !== 1'b1) begin
            errors++; $display("FAIL rmid_after got v=%0b credit=%0b exp v=0 credit=1", v_o, credit_o);
        end
        tick(1'b0, 1'b0, 1'b1, VW'(32'h700), 1'b0, '0, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 1'b0, '0, 1'b1, IW'(32'h7777), 1'b0, 1'b0);
        checks++;
        if (v_o !== 1'b1 || pc_o !== VW'(32'h700) || instr_o !== IW'(32'h7777)) begin
            errors++; $display("FAIL rmid_roundtrip got v=%0b pc=%h instr=%h exp v=1 pc=700 instr=7777", v_o, pc_o, instr_o);
        end
        tick(1'b0, 1'b0, 1'b0, '0, 1'b0, '0, 1'b0, 1'b1);
        checks++;
        if (v_o !== 1'b0 || credit_o !== 1'b1) begin
            errors++; $display("FAIL rmid_drained got v=%0b credit=%0b exp v=0 credit=1", v_o, credit_o);
        end
    endtask

    task automatic test_random();
        logic          fl;
        logic          fv;
        logic          dv;
        logic          ms;
        logic          y;
        logic [VW-1:0] va;
        logic [IW-1:0] d;
        int            r;
        tick(1'b1, 1'b0, 1'b0, '0, 1'b0, '0, 1'b0, 1'b0);
        for (int c = 0; c < 600; c++) begin
            fl = ($urandom_range(0, 29) == 0);
            fv = ($urandom_range(0, 2) != 0);
            va = VW'({$urandom(), $urandom()});
            r  = $urandom_range(0, 9);
            dv = (r < 4);
            ms = (r == 4);
            d  = $urandom();
            y  = m_v() && ($urandom_range(0, 3) != 0);
            tick(1'b0, fl, fv, va, dv, d, ms, y);
            checks++;
            if (v_o !== m_v() || credit_o !== m_credit()) begin
                errors++;
                $display("FAIL rand_hs cyc=%0d got v=%0b credit=%0b exp v=%0b credit=%0b", c, v_o, credit_o, m_v(), m_credit());
            end
            if (m_v()) begin
                checks++;
                if (pc_o !== m_pc() || instr_o !== m_instr()) begin
                    errors++;
                    $display("FAIL rand_head cyc=%0d got pc=%h instr=%h exp pc=%h instr=%h", c, pc_o, instr_o, m_pc(), m_instr());
                end
            end
        end
`ifdef BP_FE_FETCH_BUFFER_PERF_EN
        checks++;
        if (drop_cnt_o !== 32'(exp_drop) || miss_cnt_o !== 32'(exp_miss)) begin
            errors++;
            $display("FAIL rand_perf got drop=%0d miss=%0d exp drop=%0d miss=%0d", drop_cnt_o, miss_cnt_o, exp_drop, exp_miss);
        end
`endif
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        reset_i         = 1'b1;
        flush_i         = 1'b0;
        fetch_v_i       = 1'b0;
        fetch_vaddr_i   = '0;
        icache_data_i   = '0;
        icache_data_v_i = 1'b0;
        icache_miss_i   = 1'b0;
        yumi_i          = 1'b0;
        test_reset();
        test_streaming();
        test_full_credit();
        test_miss_skip();
        test_flush_in_flight();
        test_flush_corner();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
